// File: rtl/commit_arbiter_pkg.sv
// rtl/commit_arbiter_pkg.sv - shared commit packet layout, station slots and arbiter sizing
// Contents:
//   COMMIT_PACKET_SIZE      width of one commit packet
//   COMMIT_*_HI/_LO         field ranges inside a commit packet
//   COMMIT_ARB_NUM_STATIONS number of reservation stations feeding the arbiter
//   station_slot_e          slot index of each execution station on iCommitRequest
package commit_arbiter_pkg;

    localparam int COMMIT_PACKET_SIZE = 32;

    // Packet layout: RSID | WE | DST | X | Y | Z
    localparam int COMMIT_RSID_HI = 31;
    localparam int COMMIT_RSID_LO = 28;
    localparam int COMMIT_WE_BIT  = 27;
    localparam int COMMIT_DST_HI  = 26;
    localparam int COMMIT_DST_LO  = 22;
    localparam int COMMIT_X_HI    = 21;
    localparam int COMMIT_X_LO    = 14;
    localparam int COMMIT_Y_HI    = 13;
    localparam int COMMIT_Y_LO    = 7;
    localparam int COMMIT_Z_HI    = 6;
    localparam int COMMIT_Z_LO    = 0;

    localparam int COMMIT_ARB_NUM_STATIONS = 8;
    localparam int COMMIT_ARB_PTR_W        = 3;

    typedef enum logic [2:0] {
        STN_ADD  = 3'd0,
        STN_AND  = 3'd1,
        STN_MUL  = 3'd2,
        STN_OR   = 3'd3,
        STN_XOR  = 3'd4,
        STN_SHF  = 3'd5,
        STN_LOAD = 3'd6,
        STN_STOR = 3'd7
    } station_slot_e;

endpackage

// File: rtl/commit_arbiter_if.sv
// rtl/commit_arbiter_if.sv - reservation-station commit handshake bundle
// Signals:
//   iCommitRequest  per-station request, held until granted
//   iCommitData     flattened station packets, slot k at [k*PACKET_W +: PACKET_W]
//   oCommitGranted  registered one-hot grant pulse
//   oCommitBus      registered broadcast packet
//   oCommitValid    oCommitBus carries a commit this cycle
//   oIdle           nothing pending, granted or broadcasting
// Modports: master = station side, slave = arbiter side.
interface commit_arbiter_if
    import commit_arbiter_pkg::*;
#(
    parameter int NUM_STATIONS = COMMIT_ARB_NUM_STATIONS,
    parameter int PACKET_W     = COMMIT_PACKET_SIZE
);
    logic [NUM_STATIONS-1:0]          iCommitRequest;
    logic [NUM_STATIONS*PACKET_W-1:0] iCommitData;
    logic [NUM_STATIONS-1:0]          oCommitGranted;
    logic [PACKET_W-1:0]              oCommitBus;
    logic                             oCommitValid;
    logic                             oIdle;

    modport master (
        output iCommitRequest,
        output iCommitData,
        input  oCommitGranted,
        input  oCommitBus,
        input  oCommitValid,
        input  oIdle
    );

    modport slave (
        input  iCommitRequest,
        input  iCommitData,
        output oCommitGranted,
        output oCommitBus,
        output oCommitValid,
        output oIdle
    );
endinterface

// File: rtl/commit_arbiter_rr_priority_picker.sv
// rtl/commit_arbiter_rr_priority_picker.sv - combinational round-robin / fixed-priority picker
// Ports:
//   i_eligible  candidate vector
//   i_ptr       round-robin start index (ignored in fixed-priority mode)
//   o_onehot    one-hot winner, zero when nothing is eligible
//   o_index     encoded winner index
//   o_hit       some candidate won
// Macro: COMMIT_ARB_FIXED_PRIORITY_EN selects lowest-index-wins.
module commit_arbiter_rr_priority_picker
    import commit_arbiter_pkg::*;
#(
    parameter int NUM_STATIONS = COMMIT_ARB_NUM_STATIONS,
    parameter int PTR_W        = COMMIT_ARB_PTR_W
) (
    input  logic [NUM_STATIONS-1:0] i_eligible,
    input  logic [PTR_W-1:0]        i_ptr,
    output logic [NUM_STATIONS-1:0] o_onehot,
    output logic [PTR_W-1:0]        o_index,
    output logic                    o_hit
);

`ifdef COMMIT_ARB_FIXED_PRIORITY_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    // Scan downward so the lowest eligible index is the last (winning) write.
    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        o_hit    = 1'b0;
        for (int i = NUM_STATIONS - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_index     = PTR_W'(i);
                o_hit       = 1'b1;
            end
        end
    end
`else
    int w_idx;

    // Scan offsets from far to near so the smallest offset from the pointer
    // wins; the modulo provides the NUM_STATIONS-1 -> 0 wrap.
    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        o_hit    = 1'b0;
        w_idx    = 0;
        for (int off = NUM_STATIONS - 1; off >= 0; off--) begin
            w_idx = (int'(i_ptr) + off) % NUM_STATIONS;
            if (i_eligible[w_idx]) begin
                o_onehot        = '0;
                o_onehot[w_idx] = 1'b1;
                o_index         = PTR_W'(w_idx);
                o_hit           = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/commit_arbiter.sv
// rtl/commit_arbiter.sv - commit bus arbiter: round-robin grant and registered packet broadcast
// Ports:
//   Clock  system clock, rising edge
//   Reset  synchronous active-low reset
//   cbus   commit_arbiter_if.slave (requests/packets in, grant/bus/valid/idle out)
// Macro: COMMIT_ARB_FIXED_PRIORITY_EN removes the pointer and uses lowest-index-wins.
module commit_arbiter
    import commit_arbiter_pkg::*;
#(
    parameter int NUM_STATIONS = COMMIT_ARB_NUM_STATIONS,
    parameter int PACKET_W     = COMMIT_PACKET_SIZE,
    parameter int PTR_W        = COMMIT_ARB_PTR_W
) (
    input  logic             Clock,
    input  logic             Reset,
    commit_arbiter_if.slave  cbus
);

    logic [NUM_STATIONS-1:0] r_grant;
    logic [PTR_W-1:0]        r_gnt_idx;
    logic [PACKET_W-1:0]     r_bus;
    logic                    r_valid;

    logic [NUM_STATIONS-1:0] w_eligible;
    logic [NUM_STATIONS-1:0] w_onehot;
    logic [PTR_W-1:0]        w_index;
    logic                    w_hit;
    logic [PTR_W-1:0]        w_ptr;

    // The station granted this cycle still holds its request; masking it
    // prevents a double grant of the same packet.
    assign w_eligible = cbus.iCommitRequest & ~r_grant;

`ifdef COMMIT_ARB_FIXED_PRIORITY_EN
    assign w_ptr = '0;
`else
    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_ptr <= '0;
        end else if (w_hit) begin
            r_ptr <= (w_index == PTR_W'(NUM_STATIONS - 1)) ? '0 : w_index + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    commit_arbiter_rr_priority_picker #(
        .NUM_STATIONS (NUM_STATIONS),
        .PTR_W        (PTR_W)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_ptr      (w_ptr),
        .o_onehot   (w_onehot),
        .o_index    (w_index),
        .o_hit      (w_hit)
    );

    // Grant stage: one-hot grant plus its encoded index for the capture mux.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_grant   <= '0;
            r_gnt_idx <= '0;
        end else begin
            r_grant   <= w_onehot;
            r_gnt_idx <= w_index;
        end
    end

    // Capture stage: the granted station holds its packet through the grant
    // cycle, so the slot is sampled here. An idle cycle drives an all-zero bus.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_bus   <= '0;
            r_valid <= 1'b0;
        end else if (|r_grant) begin
            r_bus   <= cbus.iCommitData[int'(r_gnt_idx)*PACKET_W +: PACKET_W];
            r_valid <= 1'b1;
        end else begin
            r_bus   <= '0;
            r_valid <= 1'b0;
        end
    end

    assign cbus.oCommitGranted = r_grant;
    assign cbus.oCommitBus     = r_bus;
    assign cbus.oCommitValid   = r_valid;
    // Held high during reset even while stations still show requests.
    assign cbus.oIdle = ~Reset | (~|cbus.iCommitRequest & ~|r_grant & ~r_valid);

endmodule

// File: tb/tb_commit_arbiter.sv
// tb/tb_commit_arbiter.sv - directed self-checking bench for commit_arbiter
module tb_commit_arbiter;
    import commit_arbiter_pkg::*;

    localparam int N = 8;
    localparam int W = 32;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    commit_arbiter_if #(.NUM_STATIONS(N), .PACKET_W(W)) cif ();

    commit_arbiter #(
        .NUM_STATIONS (N),
        .PACKET_W     (W),
        .PTR_W        (3)
    ) dut (
        .Clock (clk),
        .Reset (rstn),
        .cbus  (cif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pkt(input int k);
        return 32'hC0DE_0000 + 32'(k) * 32'h0000_0101;
    endfunction

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cif.iCommitRequest = '0;
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn = 1'b0;
        cif.iCommitRequest = '0;
        for (int k = 0; k < N; k++) cif.iCommitData[k*W +: W] = pkt(k);

        // Reset with all requests high
        cif.iCommitRequest = 8'hFF;
        step();
        step();
        check_eq("rst_grant", 64'(cif.oCommitGranted), 64'h0);
        check_eq("rst_bus",   64'(cif.oCommitBus), 64'h0);
        check_eq("rst_valid", 64'(cif.oCommitValid), 64'h0);
        check_eq("rst_idle",  64'(cif.oIdle), 64'h1);
        rstn = 1'b1;
        step();
        check_eq("rst_first_grant", 64'(cif.oCommitGranted), 64'h01);
        cif.iCommitRequest = '0;
        step();
        check_eq("rst_first_bus",   64'(cif.oCommitBus), 64'(pkt(0)));
        check_eq("rst_first_valid", 64'(cif.oCommitValid), 64'h1);

        // Lone request on slot 3
        do_reset();
        cif.iCommitData[3*W +: W] = 32'hA5A5_A5A5;
        cif.iCommitRequest = 8'h08;
        check_eq("s3_no_grant_yet", 64'(cif.oCommitGranted), 64'h0);
        step();
        check_eq("s3_grant", 64'(cif.oCommitGranted), 64'h08);
        check_eq("s3_valid_early", 64'(cif.oCommitValid), 64'h0);
        step();
        check_eq("s3_bus", 64'(cif.oCommitBus), 64'hA5A5_A5A5);
        check_eq("s3_valid", 64'(cif.oCommitValid), 64'h1);
        check_eq("s3_masked", 64'(cif.oCommitGranted), 64'h0);
        cif.iCommitRequest = '0;
        check_eq("s3_idle_busy", 64'(cif.oIdle), 64'h0);
        step();
        check_eq("s3_bus_clear", 64'(cif.oCommitBus), 64'h0);
        check_eq("s3_valid_clear", 64'(cif.oCommitValid), 64'h0);
        check_eq("s3_idle", 64'(cif.oIdle), 64'h1);
        cif.iCommitData[3*W +: W] = pkt(3);

        // All stations request, each drops after its grant
        do_reset();
        cif.iCommitRequest = 8'hFF;
        for (int n = 1; n <= 9; n++) begin
            step();
            if (n <= 8) check_eq($sformatf("sweep_grant%0d", n - 1), 64'(cif.oCommitGranted), 64'(8'h01 << (n - 1)));
            else        check_eq("sweep_grant_end", 64'(cif.oCommitGranted), 64'h0);
            if (n >= 2) begin
                check_eq($sformatf("sweep_bus%0d", n - 2), 64'(cif.oCommitBus), 64'(pkt(n - 2)));
                check_eq($sformatf("sweep_valid%0d", n - 2), 64'(cif.oCommitValid), 64'h1);
                cif.iCommitRequest[n-2] = 1'b0;
            end
        end
        cif.iCommitRequest = '0;
        step();
        check_eq("sweep_valid_end", 64'(cif.oCommitValid), 64'h0);

        // Slots 5 and 2 held continuously: grants alternate, never repeat
        do_reset();
        cif.iCommitRequest = 8'h20;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 1) cif.iCommitRequest = 8'h24;
            check_eq($sformatf("alt_grant%0d", n), 64'(cif.oCommitGranted), (n % 2 == 1) ? 64'h20 : 64'h04);
            if (n >= 2)
                check_eq($sformatf("alt_bus%0d", n), 64'(cif.oCommitBus), (n % 2 == 0) ? 64'(pkt(5)) : 64'(pkt(2)));
        end
        cif.iCommitRequest = '0;
        step();
        step();

        // Reset aborts an in-flight grant to slot 6
        do_reset();
        cif.iCommitRequest = 8'h40;
        step();
        check_eq("abort_grant", 64'(cif.oCommitGranted), 64'h40);
        rstn = 1'b0;
        cif.iCommitRequest = '0;
        step();
        check_eq("abort_valid", 64'(cif.oCommitValid), 64'h0);
        check_eq("abort_bus", 64'(cif.oCommitBus), 64'h0);
        check_eq("abort_grant_clr", 64'(cif.oCommitGranted), 64'h0);
        rstn = 1'b1;
        cif.iCommitRequest = 8'hC0;
        step();
        check_eq("abort_ptr_zero", 64'(cif.oCommitGranted), 64'h40);
        cif.iCommitRequest = '0;
        step();
        step();

`ifdef COMMIT_ARB_FIXED_PRIORITY_EN
        // Slots 1 and 4 held: slot 1 wins except in its masked cycles
        do_reset();
        cif.iCommitRequest = 8'h12;
        for (int n = 1; n <= 6; n++) begin
            step();
            check_eq($sformatf("fixed_grant%0d", n), 64'(cif.oCommitGranted), (n % 2 == 1) ? 64'h02 : 64'h10);
        end
        cif.iCommitRequest = '0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
